// File: rtl/snake_collision_detector.sv
// Snake body store and move classifier: one head move per strobe, sequential
// self-collision scan, single-cycle goodColl/badColl pulses.
module snake_collision_detector #(
  parameter int COORD_W  = 4,
  parameter int GRID_MAX = 11,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               move_valid,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] apple_x,
  input  logic [COORD_W-1:0] apple_y,
  input  logic               restart,
  output logic               busy,
  output logic               goodColl,
  output logic               badColl,
  output logic               dead,
  output logic [5:0]         length
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [COORD_W-1:0] GMAX = COORD_W'(GRID_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DEAD} state_t;

  state_t             state;
  logic [COORD_W-1:0] body_x [MAX_LEN];
  logic [COORD_W-1:0] body_y [MAX_LEN];
  logic [COORD_W-1:0] hx, hy;
  logic               eat, wall, hit;
  logic [5:0]         idx, scan_last;
  logic               seg_match;

  // Initial snake lies horizontally on row 5 with the head at x=4.
  function automatic logic [COORD_W-1:0] init_x(int unsigned i);
    return (i < INIT_LEN) ? COORD_W'(4 - i) : '0;
  endfunction

  function automatic logic [COORD_W-1:0] init_y(int unsigned i);
    return (i < INIT_LEN) ? COORD_W'(5) : '0;
  endfunction

  // The tail vacates on a plain move, so it is only checked when growing.
  always_comb begin
    scan_last = eat ? (length - 6'd1) : (length - 6'd2);
    seg_match = (body_x[idx[IDX_W-1:0]] == hx) && (body_y[idx[IDX_W-1:0]] == hy);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      dead     <= 1'b0;
      length   <= 6'(INIT_LEN);
      hx       <= '0;
      hy       <= '0;
      eat      <= 1'b0;
      wall     <= 1'b0;
      hit      <= 1'b0;
      idx      <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= init_x(i);
        body_y[i] <= init_y(i);
      end
    end else if (restart) begin
      state    <= IDLE;
      busy     <= 1'b0;
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      dead     <= 1'b0;
      length   <= 6'(INIT_LEN);
      hx       <= '0;
      hy       <= '0;
      eat      <= 1'b0;
      wall     <= 1'b0;
      hit      <= 1'b0;
      idx      <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= init_x(i);
        body_y[i] <= init_y(i);
      end
    end else begin
      case (state)
        IDLE: begin
          if (move_valid) begin
            hx   <= head_x;
            hy   <= head_y;
            eat  <= (head_x == apple_x) && (head_y == apple_y);
            hit  <= 1'b0;
            idx  <= '0;
            busy <= 1'b1;
            if (head_x > GMAX || head_y > GMAX) begin
              wall    <= 1'b1;
              badColl <= 1'b1;
              state   <= UPDATE;
            end else begin
              wall  <= 1'b0;
              state <= SCAN;
            end
          end
        end
        // Pulses are loaded on the edge entering UPDATE so they are visible for its one cycle.
        SCAN: begin
          if (seg_match) begin
            hit     <= 1'b1;
            badColl <= 1'b1;
            state   <= UPDATE;
          end else if (idx == scan_last) begin
            goodColl <= eat;
            state    <= UPDATE;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        UPDATE: begin
          goodColl <= 1'b0;
          badColl  <= 1'b0;
          if (wall || hit) begin
            dead  <= 1'b1;
            state <= DEAD;
          end else begin
            for (int unsigned i = MAX_LEN - 1; i > 0; i--) begin
              body_x[i] <= body_x[i-1];
              body_y[i] <= body_y[i-1];
            end
            body_x[0] <= hx;
            body_y[0] <= hy;
            if (eat && length != 6'(MAX_LEN))
              length <= length + 6'd1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DEAD: begin
          state <= DEAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
